// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous RAM between the fetch port and the data port.
// Grants one requester per cycle, tags reads in flight and steers read data back to its owner.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MAX_DWAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // data port
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  // RAM side
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cpu_stall_o
);

  localparam logic [3:0] MaxDwait = 4'(MAX_DWAIT);

  typedef struct packed {
    logic valid;
    logic is_if;
  } tag_t;

  logic [3:0]         starve_q, starve_d;
  tag_t [MEM_LAT-1:0] tag_q, tag_d;
  tag_t               tail;
  logic               starved;
  logic               rd_gnt;

  assign starved = (starve_q == MaxDwait);

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    if (rst_n) begin
      if (if_req_i && (!d_req_i || starved)) begin
        if_gnt_o = 1'b1;
      end else if (d_req_i) begin
        d_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en_o    = if_gnt_o | d_gnt_o;
    mem_we_o    = d_gnt_o & d_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = 4'h0;
    if (if_gnt_o) begin
      mem_addr_o = if_addr_i;
      mem_be_o   = 4'hF;
    end else if (d_gnt_o) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_be_o    = d_be_i;
    end
  end

  assign cpu_stall_o = rst_n & ((if_req_i & ~if_gnt_o) | (d_req_i & ~d_gnt_o));

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = 4'd0;
    end else if (!starved) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign rd_gnt = if_gnt_o | (d_gnt_o & ~d_we_i);

  // Flush drops every fetch-owned entry that will still be in the pipe after this edge,
  // including the one entering now; the tail entry leaves on this edge regardless.
  always_comb begin
    tag_d[0].valid = rd_gnt;
    tag_d[0].is_if = if_gnt_o;
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      tag_d[i] = tag_q[i-1];
    end
    if (if_flush_i) begin
      for (int i = 0; i < int'(MEM_LAT); i++) begin
        if (tag_d[i].is_if) begin
          tag_d[i].valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
      tag_q    <= '0;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
    end
  end

  assign tail        = tag_q[MEM_LAT-1];
  assign if_rvalid_o = tail.valid & tail.is_if;
  assign d_rvalid_o  = tail.valid & ~tail.is_if;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a RAM model drives mem_rdata, and a
// transaction-level reference (grant rule, shadow memory, return list) predicts every output.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_flush, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          mem_en, mem_we, cpu_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DWAIT(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_be_i(d_be),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
    .cpu_stall_o(cpu_stall)
  );

  // RAM device: byte-masked write, read data appears LAT cycles after the strobe.
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  function automatic logic [DW-1:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we)
      ram[mem_addr] <= (ram[mem_addr] & ~be_mask(mem_be)) | (mem_wdata & be_mask(mem_be));
    rd_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model state
  typedef struct {
    int          due;
    bit          is_if;
    bit          live;
    logic [31:0] data;
  } ret_t;

  logic [DW-1:0] ref_mem [2**AW];
  ret_t          pend[$];
  int            starve;
  int            cyc;
  int            n_checks;
  int            n_errors;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
    check_eq({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
    check_eq({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    check_eq({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
    check_eq({tag, "_if_rdata"}, if_rdata, 32'd0);
    check_eq({tag, "_d_rdata"}, d_rdata, 32'd0);
    check_eq({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    check_eq({tag, "_stall"}, 32'(cpu_stall), 32'd0);
  endtask

  // Check one cycle's outputs against the reference, then advance the reference past the edge.
  task automatic cycle();
    bit          e_ifv, e_dv, e_ifg, e_dg;
    logic [31:0] e_ifd, e_dd, e_addr, e_wdata, e_be;
    ret_t        r;
    #1;
    e_ifv = 0; e_dv = 0; e_ifd = 0; e_dd = 0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc && pend[i].live) begin
        if (pend[i].is_if) begin e_ifv = 1; e_ifd = pend[i].data; end
        else begin e_dv = 1; e_dd = pend[i].data; end
      end
    end
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    check_eq("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
    check_eq("if_rdata", if_rdata, e_ifd);
    check_eq("d_rvalid", 32'(d_rvalid), 32'(e_dv));
    check_eq("d_rdata", d_rdata, e_dd);

    // Data wins a tie unless fetch has already been turned away MAXW cycles running.
    e_ifg = if_req && (!d_req || starve == int'(MAXW));
    e_dg  = d_req && !e_ifg;
    e_addr  = e_ifg ? 32'(if_addr) : (e_dg ? 32'(d_addr) : 32'd0);
    e_wdata = e_dg ? d_wdata : 32'd0;
    e_be    = e_ifg ? 32'hF : (e_dg ? 32'(d_be) : 32'd0);
    check_eq("if_gnt", 32'(if_gnt), 32'(e_ifg));
    check_eq("d_gnt", 32'(d_gnt), 32'(e_dg));
    check_eq("mem_en", 32'(mem_en), 32'(e_ifg | e_dg));
    check_eq("mem_we", 32'(mem_we), 32'(e_dg & d_we));
    check_eq("mem_addr", 32'(mem_addr), e_addr);
    check_eq("mem_wdata", mem_wdata, e_wdata);
    check_eq("mem_be", 32'(mem_be), e_be);
    check_eq("stall", 32'(cpu_stall), 32'((if_req & !e_ifg) | (d_req & !e_dg)));

    if (e_ifg) begin
      r.due = cyc + int'(LAT); r.is_if = 1; r.live = 1; r.data = ref_mem[if_addr];
      pend.push_back(r);
    end
    if (e_dg && !d_we) begin
      r.due = cyc + int'(LAT); r.is_if = 0; r.live = 1; r.data = ref_mem[d_addr];
      pend.push_back(r);
    end
    if (if_flush) foreach (pend[i]) if (pend[i].is_if && pend[i].due > cyc) pend[i].live = 0;
    if (e_dg && d_we)
      ref_mem[d_addr] = (ref_mem[d_addr] & ~be_mask(d_be)) | (d_wdata & be_mask(d_be));
    if (if_req && !e_ifg) starve = (starve < int'(MAXW)) ? starve + 1 : starve;
    else starve = 0;
    cyc++;
  endtask

  task automatic drive(input bit ir, input logic [AW-1:0] ia, input bit fl, input bit dr,
                       input bit dw, input logic [AW-1:0] da, input logic [31:0] dwd,
                       input logic [3:0] dbe);
    @(negedge clk);
    if_req = ir; if_addr = ia; if_flush = fl;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_be = dbe;
    cycle();
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, 0, '0, '0, 4'h0);
  endtask

  initial begin
    logic [31:0] v;
    n_checks = 0; n_errors = 0; starve = 0; cyc = 0;
    for (int i = 0; i < 2**AW; i++) begin
      v = $urandom;
      ram[i] = v;
      ref_mem[i] = v;
    end
    ram[4] = 32'h0050_0093; ref_mem[4] = 32'h0050_0093;
    for (int i = 0; i < int'(LAT); i++) rd_pipe[i] = '0;
    if_req = 0; if_addr = '0; if_flush = 0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; d_be = 4'h0;
    rst_n = 0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    // Fetch alone, then let it return
    drive(1, 10'h004, 0, 0, 0, '0, '0, 4'h0);
    repeat (3) idle();
    // Both request; data wins while fetch waits
    for (int i = 0; i < 3; i++) drive(1, 10'h008, 0, 1, 0, 10'h010, '0, 4'hF);
    repeat (3) idle();
    // Continuous contention: starvation forces a fetch grant periodically
    for (int i = 0; i < 12; i++) drive(1, 10'(i), 0, 1, 0, 10'(16 + i), '0, 4'hF);
    repeat (3) idle();
    // Flush kills the fetch in flight but not a data read granted alongside it
    drive(1, 10'h030, 0, 0, 0, '0, '0, 4'h0);
    drive(0, '0, 1, 1, 0, 10'h031, '0, 4'hF);
    repeat (4) idle();
    // Half-word write then read-back of the same address
    drive(0, '0, 0, 1, 1, 10'h020, 32'hDEAD_BEEF, 4'b0011);
    drive(0, '0, 0, 1, 0, 10'h020, '0, 4'hF);
    repeat (3) idle();

    // Reset with two reads in flight
    drive(1, 10'h040, 0, 0, 0, '0, '0, 4'h0);
    drive(0, '0, 0, 1, 0, 10'h041, '0, 4'hF);
    @(negedge clk);
    if_req = 1; d_req = 1; d_we = 0; if_addr = 10'h042; d_addr = 10'h043;
    #1;
    rst_n = 0;
    #1;
    check_all_zero("inflight_reset");
    pend.delete();
    starve = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    cycle();
    repeat (4) idle();

    // Random traffic over a small address window so writes and reads collide
    for (int n = 0; n < 3000; n++) begin
      drive(bit'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 31)),
            bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 2) == 0), 10'($urandom_range(0, 31)),
            $urandom, 4'($urandom_range(0, 15)));
    end
    repeat (4) idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
